display_scheduler: RTL and testbench

//  Sequences and shares the 2-digit seven-segment mux between two sources: the parking car count and the FSM alert code.

---
 rtl/display_pkg.sv | 52 +++++
 rtl/bin2bcd_seq.sv | 105 ++++++++++
 rtl/display_scheduler.sv | 148 ++++++++++++++
 tb/tb_display_scheduler.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : display_pkg
//  Purpose  : Shared segment codes, mode/converter state enums and the
//             hex-to-seven-segment (common-anode, {g,f,e,d,c,b,a}) decoder.
//  Revision : 1.0
// ============================================================================
package display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_E     = 7'h06;

    // Digit code the converter reports for an over-range (>99) value
    localparam logic [3:0] BCD_SAT   = 4'hF;

    typedef enum logic [0:0] {
        MODE_COUNT = 1'b0,
        MODE_ALERT = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        CV_IDLE = 2'd0,
        CV_SUB  = 2'd1,
        CV_DONE = 2'd2
    } cv_state_e;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module   : bin2bcd_seq
//  Purpose  : Sequential repeated-subtract binary-to-BCD converter with a
//             last-wins pending slot for values strobed while busy.
//  Revision : 1.0
// ============================================================================
module bin2bcd_seq
    import display_pkg::*;
#(
    parameter int unsigned CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] bin_in,
    output logic             busy,
    output logic             done,
    output logic [3:0]       tens,
    output logic [3:0]       units
);

    localparam logic [CNT_W-1:0] c_ten = CNT_W'(10);

    cv_state_e        r_state, w_state_nxt;
    logic [CNT_W-1:0] r_rem, w_rem_nxt;
    logic [3:0]       r_acc, w_acc_nxt;
    logic             r_sat, w_sat_nxt;
    logic [CNT_W-1:0] r_pend_val, w_pend_val_nxt;
    logic             r_pend, w_pend_nxt;
    logic [CNT_W-1:0] w_load_val;
    logic             w_load_sat;

    // A strobe arriving together with a held pending value wins (last wins)
    assign w_load_val = start ? bin_in : r_pend_val;
    assign w_load_sat = (32'(w_load_val) > 32'd99);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= CV_IDLE;
            r_rem      <= '0;
            r_acc      <= '0;
            r_sat      <= 1'b0;
            r_pend_val <= '0;
            r_pend     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rem      <= w_rem_nxt;
            r_acc      <= w_acc_nxt;
            r_sat      <= w_sat_nxt;
            r_pend_val <= w_pend_val_nxt;
            r_pend     <= w_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_rem_nxt      = r_rem;
        w_acc_nxt      = r_acc;
        w_sat_nxt      = r_sat;
        w_pend_val_nxt = r_pend_val;
        w_pend_nxt     = r_pend;
        case (r_state)
            CV_IDLE: begin
                if (start) begin
                    w_rem_nxt   = w_load_val;
                    w_acc_nxt   = '0;
                    w_sat_nxt   = w_load_sat;
                    w_state_nxt = w_load_sat ? CV_DONE : CV_SUB;
                end
            end
            CV_SUB: begin
                if (start) begin
                    w_pend_nxt     = 1'b1;
                    w_pend_val_nxt = bin_in;
                end
                if (r_rem >= c_ten) begin
                    w_rem_nxt = r_rem - c_ten;
                    w_acc_nxt = r_acc + 4'd1;
                end else begin
                    w_state_nxt = CV_DONE;
                end
            end
            CV_DONE: begin
                w_pend_nxt = 1'b0;
                if (start || r_pend) begin
                    w_rem_nxt   = w_load_val;
                    w_acc_nxt   = '0;
                    w_sat_nxt   = w_load_sat;
                    w_state_nxt = w_load_sat ? CV_DONE : CV_SUB;
                end else begin
                    w_state_nxt = CV_IDLE;
                end
            end
            default: w_state_nxt = CV_IDLE;
        endcase
    end

    assign busy  = (r_state != CV_IDLE);
    assign done  = (r_state == CV_DONE);
    assign tens  = r_sat ? BCD_SAT : r_acc;
    assign units = r_sat ? BCD_SAT : r_rem[3:0];

endmodule
`default_nettype wire

// File: rtl/display_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : display_scheduler
//  Purpose  : Shares the 2-digit seven-segment mux between the car count and
//             the alert code; generates mux_en. Optional LEADING_ZERO_BLANK_EN.
//  Revision : 1.0
// ============================================================================
module display_scheduler
    import display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50_000,
    parameter int unsigned DWELL_TICKS = 500,
    parameter int unsigned CNT_W       = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] count_val,
    input  logic             count_valid,
    input  logic             alert_req,
    input  logic [3:0]       alert_code,
    output logic             mux_en,
    output logic [6:0]       tens_seg,
    output logic [6:0]       units_seg,
    output logic             src_sel,
    output logic             conv_busy
);

    localparam int unsigned          c_pre_w     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned          c_dwell_w   = $clog2(DWELL_TICKS + 1);
    localparam logic [c_pre_w-1:0]   c_pre_last  = c_pre_w'(REFRESH_DIV - 1);
    localparam logic [c_dwell_w-1:0] c_dwell_max = c_dwell_w'(DWELL_TICKS);
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0]           c_tens_rst  = SEG_BLANK;
`else
    localparam logic [6:0]           c_tens_rst  = hex_to_seg(4'h0);
`endif

    logic [c_pre_w-1:0]   r_pre;
    mode_e                r_mode, w_mode_nxt;
    logic [c_dwell_w-1:0] r_dwell, w_dwell_nxt, w_dwell_inc;
    logic [3:0]           r_code, w_code_nxt;
    logic                 w_cv_done;
    logic [3:0]           w_cv_tens, w_cv_units;
    logic [3:0]           r_disp_tens, r_disp_units;
    logic [6:0]           w_tens_seg_nxt, w_units_seg_nxt;

    assign mux_en = (r_pre == c_pre_last);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pre <= '0;
        end else if (mux_en) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + c_pre_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mode  <= MODE_COUNT;
            r_dwell <= '0;
            r_code  <= '0;
        end else begin
            r_mode  <= w_mode_nxt;
            r_dwell <= w_dwell_nxt;
            r_code  <= w_code_nxt;
        end
    end

    // Dwell counts the ticks spent in alert including the current one
    assign w_dwell_inc = (r_dwell == c_dwell_max) ? r_dwell : r_dwell + c_dwell_w'(1);

    always_comb begin
        w_mode_nxt  = r_mode;
        w_dwell_nxt = r_dwell;
        w_code_nxt  = r_code;
        if (mux_en) begin
            if (r_mode == MODE_COUNT) begin
                if (alert_req) begin
                    w_mode_nxt  = MODE_ALERT;
                    w_code_nxt  = alert_code;
                    w_dwell_nxt = '0;
                end
            end else begin
                w_dwell_nxt = w_dwell_inc;
                w_code_nxt  = alert_code;
                if (!alert_req && (32'(w_dwell_inc) >= DWELL_TICKS)) begin
                    w_mode_nxt = MODE_COUNT;
                end
            end
        end
    end

    bin2bcd_seq #(
        .CNT_W (CNT_W)
    ) u_bcd (
        .clk    (clk),
        .rst    (rst),
        .start  (count_valid),
        .bin_in (count_val),
        .busy   (conv_busy),
        .done   (w_cv_done),
        .tens   (w_cv_tens),
        .units  (w_cv_units)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_disp_tens  <= '0;
            r_disp_units <= '0;
        end else if (w_cv_done) begin
            r_disp_tens  <= w_cv_tens;
            r_disp_units <= w_cv_units;
        end
    end

    always_comb begin
        w_tens_seg_nxt  = hex_to_seg(r_disp_tens);
        w_units_seg_nxt = hex_to_seg(r_disp_units);
        if (r_mode == MODE_ALERT) begin
            w_tens_seg_nxt  = SEG_E;
            w_units_seg_nxt = hex_to_seg(r_code);
        end else if (r_disp_tens > 4'd9) begin
            w_tens_seg_nxt  = SEG_DASH;
            w_units_seg_nxt = SEG_DASH;
        end
`ifdef LEADING_ZERO_BLANK_EN
        else if (r_disp_tens == 4'd0) begin
            w_tens_seg_nxt = SEG_BLANK;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tens_seg  <= c_tens_rst;
            units_seg <= hex_to_seg(4'h0);
            src_sel   <= 1'b0;
        end else begin
            tens_seg  <= w_tens_seg_nxt;
            units_seg <= w_units_seg_nxt;
            src_sel   <= (r_mode == MODE_ALERT);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_display_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_display_scheduler
//  Purpose  : Self-checking bench: duration-based reference model, decode
//             table, directed corner sequences and randomized traffic.
//  Revision : 1.0
// ============================================================================
module tb_display_scheduler;

    localparam int DIV   = 4;
    localparam int DWELL = 2;
    localparam int CW    = 7;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] ZT = 7'h7F;
`else
    localparam logic [6:0] ZT = 7'h40;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          count_valid = 1'b0;
    logic          alert_req = 1'b0;
    logic [CW-1:0] count_val = '0;
    logic [3:0]    alert_code = '0;
    logic          mux_en, src_sel, conv_busy;
    logic [6:0]    tens_seg, units_seg;

    always #5 clk = ~clk;

    display_scheduler #(
        .REFRESH_DIV (DIV),
        .DWELL_TICKS (DWELL),
        .CNT_W       (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .count_val   (count_val),
        .count_valid (count_valid),
        .alert_req   (alert_req),
        .alert_code  (alert_code),
        .mux_en      (mux_en),
        .tens_seg    (tens_seg),
        .units_seg   (units_seg),
        .src_sel     (src_sel),
        .conv_busy   (conv_busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Busy cycles a value occupies the converter: tens subtractions plus exit and commit
    function automatic int dur(input int v);
        return (v > 99) ? 1 : v / 10 + 2;
    endfunction

    // Reference model: conversions as timed jobs, arbiter as tick counting
    int         m_cyc, m_left, m_cur, m_pend, m_disp, m_ticks;
    bit         m_pend_ok, m_alert, m_tick;
    logic [3:0] m_code;
    logic [6:0] e_tens, e_units;
    bit         e_src;

    always @(posedge clk) begin
        if (!rst) begin
            m_cyc = 0; m_left = 0; m_pend_ok = 1'b0; m_disp = 0;
            m_alert = 1'b0; m_ticks = 0; m_code = 4'h0;
            e_tens = ZT; e_units = 7'h40; e_src = 1'b0;
        end else begin
            m_tick = (m_cyc % DIV == DIV - 1);
            if (m_alert) begin
                e_tens = 7'h06; e_units = seg_tab[m_code];
            end else if (m_disp > 99) begin
                e_tens = 7'h3F; e_units = 7'h3F;
            end else begin
                e_tens  = (m_disp < 10) ? ZT : seg_tab[m_disp / 10];
                e_units = seg_tab[m_disp % 10];
            end
            e_src = m_alert;
            if (m_left == 0) begin
                if (count_valid) begin m_cur = int'(count_val); m_left = dur(m_cur); end
            end else if (m_left == 1) begin
                m_disp = m_cur;
                if (count_valid) begin m_cur = int'(count_val); m_left = dur(m_cur); end
                else if (m_pend_ok) begin m_cur = m_pend; m_left = dur(m_cur); end
                else m_left = 0;
                m_pend_ok = 1'b0;
            end else begin
                m_left--;
                if (count_valid) begin m_pend = int'(count_val); m_pend_ok = 1'b1; end
            end
            if (m_tick) begin
                if (!m_alert) begin
                    if (alert_req) begin m_alert = 1'b1; m_code = alert_code; m_ticks = 0; end
                end else begin
                    m_ticks++;
                    m_code = alert_code;
                    if (m_ticks >= DWELL && !alert_req) m_alert = 1'b0;
                end
            end
            m_cyc++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_mux_en", mux_en, (m_cyc % DIV == DIV - 1));
            check("model_conv_busy", conv_busy, (m_left > 0));
            check("model_src_sel", src_sel, e_src);
            check("model_tens_seg", tens_seg, e_tens);
            check("model_units_seg", units_seg, e_units);
        end
    end

    typedef struct {
        int         val;
        logic [6:0] t;
        logic [6:0] u;
    } vec_t;
    vec_t tab [10];

    initial begin
        int  k, nb, i23, i41;
        bit  s23, s41, s99, sd;

        tab[0] = '{57,  7'h12, 7'h78};
        tab[1] = '{8,   ZT,    7'h00};
        tab[2] = '{0,   ZT,    7'h40};
        tab[3] = '{99,  7'h10, 7'h10};
        tab[4] = '{100, 7'h3F, 7'h3F};
        tab[5] = '{10,  7'h79, 7'h40};
        tab[6] = '{35,  7'h30, 7'h12};
        tab[7] = '{64,  7'h02, 7'h19};
        tab[8] = '{127, 7'h3F, 7'h3F};
        tab[9] = '{20,  7'h24, 7'h40};

        // Reset state and prescaler phase
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_tens_seg", tens_seg, ZT);
        check("rst_units_seg", units_seg, 7'h40);
        check("rst_src_sel", src_sel, 1'b0);
        check("rst_conv_busy", conv_busy, 1'b0);
        rst = 1'b1;
        #1 check("pre_cycle1", mux_en, 1'b0);
        for (int c = 2; c <= 12; c++) begin
            @(negedge clk);
            check($sformatf("pre_cycle%0d", c), mux_en, (c % 4 == 0));
        end

        // 57 keeps the converter busy for 7 cycles
        count_val = 7'd57; count_valid = 1'b1;
        nb = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            count_valid = 1'b0;
            if (conv_busy) nb++;
        end
        check("busy_len_57", nb, 7);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            count_val = 7'(tab[i].val); count_valid = 1'b1;
            @(negedge clk);
            count_valid = 1'b0;
            repeat ((tab[i].val > 99) ? 2 : tab[i].val / 10 + 3) @(negedge clk);
            check($sformatf("tab%0d_tens", i), tens_seg, tab[i].t);
            check($sformatf("tab%0d_units", i), units_seg, tab[i].u);
            check($sformatf("tab%0d_idle", i), conv_busy, 1'b0);
        end

        // Overrun: 23 then 99, 41 while busy
        @(negedge clk); count_val = 7'd23; count_valid = 1'b1;
        @(negedge clk); count_val = 7'd99;
        @(negedge clk); count_val = 7'd41;
        s23 = 0; s41 = 0; s99 = 0; i23 = -1; i41 = -1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            count_valid = 1'b0;
            if (tens_seg == 7'h24 && units_seg == 7'h30 && !s23) begin s23 = 1; i23 = c; end
            if (tens_seg == 7'h19 && units_seg == 7'h79 && !s41) begin s41 = 1; i41 = c; end
            if (tens_seg == 7'h10 && units_seg == 7'h10) s99 = 1;
        end
        check("ovr_saw23", s23, 1'b1);
        check("ovr_saw41", s41, 1'b1);
        check("ovr_order", (i23 >= 0 && i23 < i41), 1'b1);
        check("ovr_no99", s99, 1'b0);

        // Saturation shows dashes within 3 cycles
        @(negedge clk); count_val = 7'd120; count_valid = 1'b1;
        sd = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            count_valid = 1'b0;
            if (tens_seg == 7'h3F && units_seg == 7'h3F) sd = 1;
        end
        check("sat_dash", sd, 1'b1);

        // Alert entry at next tick, then exit on the second tick after dropping
        @(negedge clk); alert_code = 4'd4; alert_req = 1'b1;
        k = 0;
        while (!mux_en && k < 8) begin @(negedge clk); k++; end
        check("alert_tick0", mux_en, 1'b1);
        check("alert_src_pre", src_sel, 1'b0);
        @(negedge clk); check("alert_src_lag", src_sel, 1'b0);
        @(negedge clk);
        check("alert_src", src_sel, 1'b1);
        check("alert_tens", tens_seg, 7'h06);
        check("alert_units", units_seg, 7'h19);
        k = 0;
        while (!mux_en && k < 8) begin @(negedge clk); k++; end
        check("alert_tick1", mux_en, 1'b1);
        @(negedge clk); alert_req = 1'b0;
        k = 0;
        while (!mux_en && k < 8) begin @(negedge clk); k++; end
        check("alert_tick2", mux_en, 1'b1);
        check("alert_hold", src_sel, 1'b1);
        @(negedge clk); check("alert_exit_lag", src_sel, 1'b1);
        @(negedge clk);
        check("alert_exit", src_sel, 1'b0);
        check("alert_exit_dash", tens_seg, 7'h3F);

        // Reset during conversion while alert shown
        alert_code = 4'd9; alert_req = 1'b1;
        k = 0;
        while (!src_sel && k < 12) begin @(negedge clk); k++; end
        check("rmid_alert", src_sel, 1'b1);
        count_val = 7'd57; count_valid = 1'b1;
        @(negedge clk); count_valid = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        check("rmid_src", src_sel, 1'b0);
        check("rmid_busy", conv_busy, 1'b0);
        check("rmid_tens", tens_seg, ZT);
        check("rmid_units", units_seg, 7'h40);
        alert_req = 1'b0; rst = 1'b1;

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            count_valid = ($urandom_range(0, 5) == 0);
            count_val   = 7'($urandom_range(0, 127));
            alert_code  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) alert_req = ~alert_req;
            rst = ($urandom_range(0, 699) != 0);
        end
        @(negedge clk); rst = 1'b1; count_valid = 1'b0;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
